// File: rtl/cdma_a_rd_split_pkg.sv
// Shared types and default widths for the CDMA read-command splitter.
package cdma_a_rd_split_pkg;

    localparam int unsigned HBM_ADDR_BITS        = 64;
    localparam int unsigned HBM_LEN_BITS         = 28;
    localparam int unsigned CDMA_CHUNK_BITS      = 12;
    localparam int unsigned CDMA_MAX_OUTSTANDING = 16;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StCmpl
    } split_state_e;

endpackage

// File: rtl/cdma_a_rd_split_if.sv
// Descriptor, chunk-command and completion signals of the CDMA read-command splitter.
interface cdma_a_rd_split_if
    import cdma_a_rd_split_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = HBM_ADDR_BITS,
    parameter int unsigned LEN_BITS   = HBM_LEN_BITS,
    parameter int unsigned CHUNK_BITS = CDMA_CHUNK_BITS
) ();

    logic                             s_req_valid;
    logic                             s_req_ready;
    logic [ADDR_BITS-1:0]             s_req_addr;
    logic [LEN_BITS-1:0]              s_req_len;
    logic                             rd_valid;
    logic                             rd_ready;
    logic [ADDR_BITS-1:0]             rd_paddr;
    logic [LEN_BITS-1:0]              rd_len;
    logic                             rd_done;
    logic                             cmpl_pulse;
    logic [LEN_BITS-CHUNK_BITS:0]     cmpl_chunks;
    logic                             busy;

    // The splitter drives chunk commands toward the read engine.
    modport master (
        input  s_req_valid, s_req_addr, s_req_len, rd_ready, rd_done,
        output s_req_ready, rd_valid, rd_paddr, rd_len, cmpl_pulse, cmpl_chunks, busy
    );

    modport slave (
        output s_req_valid, s_req_addr, s_req_len, rd_ready, rd_done,
        input  s_req_ready, rd_valid, rd_paddr, rd_len, cmpl_pulse, cmpl_chunks, busy
    );

endinterface

// File: rtl/cdma_a_rd_split.sv
// Splits one read descriptor into chunk commands that never cross a 2^CHUNK_BITS boundary,
// limits chunks in flight, and pulses completion once every chunk is done.
module cdma_a_rd_split
    import cdma_a_rd_split_pkg::*;
#(
    parameter int unsigned ADDR_BITS       = HBM_ADDR_BITS,
    parameter int unsigned LEN_BITS        = HBM_LEN_BITS,
    parameter int unsigned CHUNK_BITS      = CDMA_CHUNK_BITS,
    parameter int unsigned MAX_OUTSTANDING = CDMA_MAX_OUTSTANDING
) (
    input logic               aclk,
    input logic               aresetn,
    cdma_a_rd_split_if.master bus
);

    localparam int unsigned CNT_BITS = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned NCH_BITS = LEN_BITS - CHUNK_BITS + 1;
    localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_OUTSTANDING);

    split_state_e         state_q, state_d;
    logic [ADDR_BITS-1:0] cur_addr_q;
    logic [LEN_BITS-1:0]  rem_q;
    logic [NCH_BITS-1:0]  nchunk_q;
    logic [CNT_BITS-1:0]  outst_q, outst_d;
    logic                 rd_valid_q;
    logic [ADDR_BITS-1:0] rd_paddr_q;
    logic [LEN_BITS-1:0]  rd_len_q;
    logic                 req_ready_q, req_ready_d;
    logic                 cmpl_pulse_q;
    logic [NCH_BITS-1:0]  cmpl_chunks_q;
    logic                 accept, load, handshake, done_eff;
    logic [LEN_BITS-1:0]  clen;

    // Bytes up to the next chunk boundary, capped by what is left of the descriptor.
    function automatic logic [LEN_BITS-1:0] chunk_len(input logic [LEN_BITS-1:0]   rem,
                                                      input logic [CHUNK_BITS-1:0] offset);
        logic [LEN_BITS:0] room;
        room             = '0;
        room[CHUNK_BITS] = 1'b1;
        room             = room - {{(LEN_BITS + 1 - CHUNK_BITS){1'b0}}, offset};
        return ({1'b0, rem} < room) ? rem : room[LEN_BITS-1:0];
    endfunction

    always_comb begin
        clen      = chunk_len(rem_q, cur_addr_q[CHUNK_BITS-1:0]);
        handshake = rd_valid_q & bus.rd_ready;
        done_eff  = bus.rd_done & (outst_q != '0);
        outst_d   = outst_q;
        if (handshake && !done_eff) begin
            outst_d = outst_q + CNT_BITS'(1);
        end else if (!handshake && done_eff) begin
            outst_d = outst_q - CNT_BITS'(1);
        end
        accept      = (state_q == StIdle) & req_ready_q & bus.s_req_valid;
        // Gate on the post-handshake count so the counter never exceeds the limit.
        load        = (state_q == StIssue) & (~rd_valid_q | bus.rd_ready) & (rem_q != '0) &
                      (outst_d < MAX_CNT);
        req_ready_d = (state_q == StIdle) & ~accept;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (bus.s_req_len == '0) ? StCmpl : StIssue;
                end
            end
            StIssue: begin
                if (handshake && rem_q == '0) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (outst_d == '0) begin
                    state_d = StCmpl;
                end
            end
            StCmpl:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.s_req_ready = req_ready_q;
        bus.busy        = (state_q != StIdle);
        bus.rd_valid    = rd_valid_q;
        bus.rd_paddr    = rd_paddr_q;
        bus.rd_len      = rd_len_q;
        bus.cmpl_pulse  = cmpl_pulse_q;
        bus.cmpl_chunks = cmpl_chunks_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cur_addr_q    <= '0;
            rem_q         <= '0;
            nchunk_q      <= '0;
            outst_q       <= '0;
            rd_valid_q    <= 1'b0;
            rd_paddr_q    <= '0;
            rd_len_q      <= '0;
            req_ready_q   <= 1'b0;
            cmpl_pulse_q  <= 1'b0;
            cmpl_chunks_q <= '0;
        end else begin
            req_ready_q   <= req_ready_d;
            outst_q       <= outst_d;
            cmpl_pulse_q  <= (state_q == StCmpl);
            cmpl_chunks_q <= (state_q == StCmpl) ? nchunk_q : '0;
            if (accept) begin
                cur_addr_q <= bus.s_req_addr;
                rem_q      <= bus.s_req_len;
                nchunk_q   <= '0;
            end else if (load) begin
                cur_addr_q <= cur_addr_q + ADDR_BITS'(clen);
                rem_q      <= rem_q - clen;
                nchunk_q   <= nchunk_q + NCH_BITS'(1);
            end
            if (load) begin
                rd_valid_q <= 1'b1;
                rd_paddr_q <= cur_addr_q;
                rd_len_q   <= clen;
            end else if (handshake) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdma_a_rd_split.sv
// Directed and randomized descriptors checked against a chunk-list model of the splitter.
module tb_cdma_a_rd_split;
    import cdma_a_rd_split_pkg::*;

    localparam int unsigned AB = HBM_ADDR_BITS;
    localparam int unsigned LB = HBM_LEN_BITS;
    localparam int unsigned CB = CDMA_CHUNK_BITS;
    localparam int unsigned MO = 16;
    localparam longint unsigned CHUNK = 64'd1 << CB;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    cdma_a_rd_split_if #(.ADDR_BITS(AB), .LEN_BITS(LB), .CHUNK_BITS(CB)) bus ();

    cdma_a_rd_split #(
        .ADDR_BITS(AB),
        .LEN_BITS(LB),
        .CHUNK_BITS(CB),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // One descriptor through the DUT while acting as the read engine.
    task automatic run_desc(input logic [AB-1:0] addr, input logic [LB-1:0] len,
                            input int ready_pct, input int done_pct, input int hold0,
                            input int nodone, input bit chk_stall, input int stop_hs);
        logic [AB-1:0]    a;
        longint unsigned  r, c;
        logic [AB+LB-1:0] exp_q[$];
        logic [AB+LB-1:0] prev_cmd;
        int nch, pending, hs_cnt, acc_cyc, last_done, rel, hold;
        bit hs, dn_eff, got_cmpl, seen_v, prev_v, expect_v;

        a = addr;
        r = longint'(len);
        while (r != 0) begin
            c = CHUNK - (a % CHUNK);
            if (r < c) c = r;
            exp_q.push_back({a, LB'(c)});
            a = a + c;
            r = r - c;
        end
        nch       = exp_q.size();
        pending   = 0;
        hs_cnt    = 0;
        last_done = 0;
        hold      = hold0;
        got_cmpl  = 0;
        seen_v    = 0;
        prev_v    = 0;
        expect_v  = 0;
        prev_cmd  = '0;

        for (int i = 0; i < 50 && !bus.s_req_ready; i++) step();
        chk("req_ready", bus.s_req_ready, 1);
        bus.s_req_valid = 1'b1;
        bus.s_req_addr  = addr;
        bus.s_req_len   = len;
        acc_cyc         = cyc;
        step();
        bus.s_req_valid = 1'b0;

        for (int k = 0; k < 4000 && !got_cmpl; k++) begin
            rel = cyc - acc_cyc;
            if (rel == 1) chk("busy", bus.busy, 1);
            if (prev_v) chk("hold", {bus.rd_valid, bus.rd_paddr, bus.rd_len}, {1'b1, prev_cmd});
            if (expect_v) chk("release", bus.rd_valid, 1);
            expect_v = 0;
            if (bus.rd_valid && !seen_v) begin
                seen_v = 1;
                chk("first_lat", cyc - acc_cyc, 2);
            end
            if (chk_stall && rel == nodone) begin
                chk("stall_hs", hs_cnt, MO);
                chk("stall_valid", bus.rd_valid, 0);
            end
            if (bus.cmpl_pulse) begin
                got_cmpl = 1;
                chk("cmpl_chunks", bus.cmpl_chunks, nch);
                chk("ready_at_pulse", bus.s_req_ready, 0);
                if (len == '0) chk("cmpl_lat_zero", cyc - acc_cyc, 2);
                else chk("cmpl_lat_done", cyc - last_done, 2);
            end

            if (hold > 0 && bus.rd_valid) begin
                bus.rd_ready = 1'b0;
                hold--;
            end else begin
                bus.rd_ready = ($urandom_range(99) < ready_pct);
            end
            bus.rd_done = (rel >= nodone) && ($urandom_range(99) < done_pct);
            if (chk_stall && rel == nodone) begin
                bus.rd_done = 1'b1;
                expect_v    = 1;
            end

            hs     = bus.rd_valid && bus.rd_ready;
            dn_eff = bus.rd_done && (pending > 0);
            if (hs) begin
                hs_cnt++;
                if (exp_q.size() > 0) chk("chunk", {bus.rd_paddr, bus.rd_len}, exp_q.pop_front());
                else chk("extra_chunk", hs_cnt, nch);
            end
            if (dn_eff) last_done = cyc;
            pending = pending + int'(hs) - int'(dn_eff);
            if (hs) chk("outstanding_max", pending > MO, 0);
            prev_v   = bus.rd_valid && !hs;
            prev_cmd = {bus.rd_paddr, bus.rd_len};
            step();
            if (stop_hs != 0 && hs_cnt >= stop_hs) break;
        end

        bus.rd_ready = 1'b0;
        bus.rd_done  = 1'b0;
        if (stop_hs == 0) begin
            chk("cmpl_seen", got_cmpl, 1);
            chk("chunks_left", exp_q.size(), 0);
            chk("valid_seen", seen_v, len != '0);
            chk("ready_after", bus.s_req_ready, 1);
            chk("idle_after", bus.busy, 0);
        end
    endtask

    initial begin
        bus.s_req_valid = 1'b0;
        bus.s_req_addr  = '0;
        bus.s_req_len   = '0;
        bus.rd_ready    = 1'b0;
        bus.rd_done     = 1'b0;
        step();
        step();
        chk("rst_valid", bus.rd_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.s_req_ready, 0);
        chk("rst_pulse", bus.cmpl_pulse, 0);
        chk("rst_chunks", bus.cmpl_chunks, 0);
        aresetn = 1'b1;
        step();
        chk("ready_out_of_reset", bus.s_req_ready, 1);

        // aligned, unaligned, zero length, address wrap
        run_desc(64'h1000, 28'h3000, 100, 100, 0, 0, 0, 0);
        run_desc(64'h0F80, 28'h1100, 100, 100, 0, 0, 0, 0);
        run_desc(64'h5555_0000, 28'h0, 100, 100, 0, 0, 0, 0);
        run_desc(64'hFFFF_FFFF_FFFF_FF00, 28'h200, 100, 100, 0, 0, 0, 0);
        // backpressure: 10 cycles of rd_ready low with a chunk presented
        run_desc(64'h2_0040, 28'h2000, 100, 100, 10, 0, 0, 0);
        // throttle: 32 chunks with no rd_done until the limit has stalled issue
        run_desc(64'h10_0000, 28'h20000, 100, 60, 0, 30, 1, 0);

        // reset with five chunks outstanding, stray rd_done afterwards
        run_desc(64'h4_0000, 28'h10000, 100, 0, 0, 0, 0, 5);
        aresetn = 1'b0;
        #1;
        chk("midrst_valid", bus.rd_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_ready", bus.s_req_ready, 0);
        step();
        aresetn     = 1'b1;
        bus.rd_done = 1'b1;
        step();
        step();
        bus.rd_done = 1'b0;
        chk("postrst_ready", bus.s_req_ready, 1);
        chk("postrst_busy", bus.busy, 0);
        chk("postrst_valid", bus.rd_valid, 0);
        run_desc(64'h7_0800, 28'h2800, 100, 100, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            logic [AB-1:0] ra;
            logic [LB-1:0] rl;
            ra = {$urandom, $urandom};
            if (i == 0) ra[AB-1:CB] = '1;
            rl = LB'($urandom_range(0, 24576));
            run_desc(ra, rl, $urandom_range(30, 100), $urandom_range(20, 90), 0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
